// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: registered result/flags, iterative multiply and
// optional restoring divider (enabled by defining SEQ_ALU_DIV_EN).
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       operation,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t           state;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] hi, lo, opb;
   logic [SHW-1:0]   cnt;

   logic             accept, is_mul, is_div;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sc_res;
   logic             sc_c, sc_v;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] step_hi, step_lo, fin;

   assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign busy      = (state == MUL) || (state == DIV);
   assign is_mul    = (operation == 4'd8) || (operation == 4'd9);

   always_comb begin
      sum    = '0;
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      case (operation)
         4'd0: begin
            sum    = {1'b0, a} + {1'b0, b};
            sc_res = sum[WIDTH-1:0];
            sc_c   = sum[WIDTH];
            sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
         end
         4'd1: begin
            // bit WIDTH of the widened difference is the unsigned borrow
            sum    = {1'b0, a} - {1'b0, b};
            sc_res = sum[WIDTH-1:0];
            sc_c   = sum[WIDTH];
            sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
         end
         4'd2: sc_res = a & b;
         4'd3: sc_res = a | b;
         4'd4: sc_res = a ^ b;
         4'd5: sc_res = a << b[SHW-1:0];
         4'd6: sc_res = a >> b[SHW-1:0];
         4'd7: sc_res = $unsigned($signed(a) >>> b[SHW-1:0]);
         default: sc_res = '0;
      endcase
   end

   // Shift-add: {hi,lo} starts as {0,a}; after WIDTH steps it holds a*b.
   assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});

`ifdef SEQ_ALU_DIV_EN
   logic [WIDTH:0]   div_sh;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;

   assign is_div = (operation == 4'd10) || (operation == 4'd11);

   // Restoring divide: hi = partial remainder, lo = dividend shifting into quotient.
   // A zero divisor always "fits", yielding all-ones quotient and remainder a.
   assign div_sh   = {hi, lo[WIDTH-1]};
   assign div_ge   = div_sh >= {1'b0, opb};
   assign div_diff = div_sh[WIDTH-1:0] - opb;

   always_comb begin
      if (state == DIV) begin
         step_hi = div_ge ? div_diff : div_sh[WIDTH-1:0];
         step_lo = {lo[WIDTH-2:0], div_ge};
         fin     = (op_q == 4'd11) ? step_hi : step_lo;
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], lo[WIDTH-1:1]};
         fin     = (op_q == 4'd9) ? step_hi : step_lo;
      end
   end
`else
   assign is_div  = 1'b0;
   assign step_hi = mul_sum[WIDTH:1];
   assign step_lo = {mul_sum[0], lo[WIDTH-1:1]};
   assign fin     = (op_q == 4'd9) ? step_hi : step_lo;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op_q     <= '0;
         hi       <= '0;
         lo       <= '0;
         opb      <= '0;
         cnt      <= '0;
         result   <= '0;
         zero     <= 1'b0;
         negative <= 1'b0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  op_q <= operation;
                  opb  <= b;
                  hi   <= '0;
                  lo   <= a;
                  cnt  <= '0;
                  if (is_mul) begin
                     state <= MUL;
                  end else if (is_div) begin
                     state <= DIV;
                  end else begin
                     state    <= DONE;
                     result   <= sc_res;
                     zero     <= (sc_res == '0);
                     negative <= sc_res[WIDTH-1];
                     carry    <= sc_c;
                     overflow <= sc_v;
                  end
               end else if (state == DONE && out_ready) begin
                  state <= IDLE;
               end
            end
            MUL, DIV: begin
               hi  <= step_hi;
               lo  <= step_lo;
               cnt <= cnt + 1'b1;
               if (cnt == '1) begin
                  state    <= DONE;
                  result   <= fin;
                  zero     <= (fin == '0);
                  negative <= fin[WIDTH-1];
                  carry    <= 1'b0;
                  overflow <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32); DIV checks follow SEQ_ALU_DIV_EN.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  operation;
   logic [31:0] a, b, result;
   logic        zero, negative, carry, overflow, busy;
   int unsigned total = 0;
   int unsigned bad = 0;

   seq_alu #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .operation(operation), .a(a), .b(b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .negative(negative),
      .carry(carry), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one request for a single edge, then drop in_valid.
   task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
      operation = op;
      a         = av;
      b         = bv;
      in_valid  = 1'b1;
      step();
      in_valid  = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      total++;
      if (out_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s timeout: out_valid=%b required 1", name, out_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; operation = '0; a = '0; b = '0;
      step(); step();
      rst = 1'b0;
      total++;
      if ({out_valid, busy, in_ready, zero, negative, carry, overflow} !== 7'b0010000 || result !== 32'h0) begin
         bad++;
         $display("FAIL reset: v/b/r/z/n/c/o=%b result=%h required 0010000 result=0",
                  {out_valid, busy, in_ready, zero, negative, carry, overflow}, result);
      end
   endtask

   task automatic test_addsub();
      issue(4'd0, 32'hFFFF_FFFF, 32'h1);
      total++;
      if (out_valid !== 1'b1 || result !== 32'h0 || {zero, negative, carry, overflow} !== 4'b1010) begin
         bad++;
         $display("FAIL add_carry: v=%b result=%h znco=%b required v=1 0 1010", out_valid, result,
                  {zero, negative, carry, overflow});
      end
      step();
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL add_drop: out_valid=%b required 0", out_valid);
      end
      issue(4'd0, 32'h7FFF_FFFF, 32'h1);
      total++;
      if (result !== 32'h8000_0000 || {zero, negative, carry, overflow} !== 4'b0101) begin
         bad++;
         $display("FAIL add_ovf: result=%h znco=%b required 80000000 0101", result,
                  {zero, negative, carry, overflow});
      end
      step();
      issue(4'd1, 32'd3, 32'd5);
      total++;
      if (result !== 32'hFFFF_FFFE || {zero, negative, carry, overflow} !== 4'b0110) begin
         bad++;
         $display("FAIL sub_borrow: result=%h znco=%b required fffffffe 0110", result,
                  {zero, negative, carry, overflow});
      end
      step();
      issue(4'd1, 32'h8000_0000, 32'h1);
      total++;
      if (result !== 32'h7FFF_FFFF || {zero, negative, carry, overflow} !== 4'b0001) begin
         bad++;
         $display("FAIL sub_ovf: result=%h znco=%b required 7fffffff 0001", result,
                  {zero, negative, carry, overflow});
      end
      step();
   endtask

   task automatic test_shift();
      issue(4'd7, 32'h8000_0000, 32'h24);
      total++;
      if (result !== 32'hF800_0000 || {zero, negative, carry, overflow} !== 4'b0100) begin
         bad++;
         $display("FAIL sra: result=%h znco=%b required f8000000 0100", result,
                  {zero, negative, carry, overflow});
      end
      step();
      issue(4'd5, 32'h1, 32'd31);
      total++;
      if (result !== 32'h8000_0000) begin
         bad++;
         $display("FAIL sll: result=%h required 80000000", result);
      end
      step();
      issue(4'd6, 32'h8000_0000, 32'h21);
      total++;
      if (result !== 32'h4000_0000) begin
         bad++;
         $display("FAIL srl: result=%h required 40000000", result);
      end
      step();
   endtask

   task automatic test_mul();
      logic held = 1'b1;
      issue(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int i = 0; i < 32; i++) begin
         if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) held = 1'b0;
         step();
      end
      total++;
      if (held !== 1'b1) begin
         bad++;
         $display("FAIL mul_busy: busy/in_ready held=%b required 1", held);
      end
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b0 || result !== 32'hFFFF_FFFE || carry !== 1'b0) begin
         bad++;
         $display("FAIL mulhu: v=%b busy=%b result=%h c=%b required 1 0 fffffffe 0", out_valid, busy,
                  result, carry);
      end
      step();
      issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mul");
      total++;
      if (result !== 32'h0000_0001) begin
         bad++;
         $display("FAIL mul: result=%h required 00000001", result);
      end
      step();
      issue(4'd8, 32'd1234, 32'd5678);
      wait_done("mul2");
      total++;
      if (result !== 32'd7006652) begin
         bad++;
         $display("FAIL mul2: result=%h required %h", result, 32'd7006652);
      end
      step();
   endtask

   task automatic test_div();
`ifdef SEQ_ALU_DIV_EN
      issue(4'd10, 32'd100, 32'd7);
      wait_done("divu");
      total++;
      if (result !== 32'd14) begin bad++; $display("FAIL divu: result=%h required e", result); end
      step();
      issue(4'd11, 32'd100, 32'd7);
      wait_done("remu");
      total++;
      if (result !== 32'd2) begin bad++; $display("FAIL remu: result=%h required 2", result); end
      step();
      issue(4'd10, 32'd5, 32'd0);
      wait_done("divu0");
      total++;
      if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu0: result=%h required ffffffff", result); end
      step();
      issue(4'd11, 32'd5, 32'd0);
      wait_done("remu0");
      total++;
      if (result !== 32'd5) begin bad++; $display("FAIL remu0: result=%h required 5", result); end
      step();
`else
      issue(4'd10, 32'd100, 32'd7);
      total++;
      if (out_valid !== 1'b1 || busy !== 1'b0 || result !== 32'h0 || {zero, carry, overflow} !== 3'b100) begin
         bad++;
         $display("FAIL divu_off: v=%b busy=%b result=%h zco=%b required 1 0 0 100", out_valid, busy,
                  result, {zero, carry, overflow});
      end
      step();
`endif
      issue(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      total++;
      if (out_valid !== 1'b1 || result !== 32'h0 || {zero, negative, carry, overflow} !== 4'b1000) begin
         bad++;
         $display("FAIL op13: v=%b result=%h znco=%b required 1 0 1000", out_valid, result,
                  {zero, negative, carry, overflow});
      end
      step();
   endtask

   task automatic test_back_to_back();
      operation = 4'd0; a = 32'd1; b = 32'd2; in_valid = 1'b1;
      step();
      operation = 4'd2; a = 32'hF0F0_1234; b = 32'h0FF0_FFFF;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== 32'd3) begin
         bad++;
         $display("FAIL b2b_first: v=%b rdy=%b result=%h required 1 1 3", out_valid, in_ready, result);
      end
      step();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || result !== 32'h00F0_1234) begin
         bad++;
         $display("FAIL b2b_second: v=%b result=%h required 1 00f01234", out_valid, result);
      end
      step();
   endtask

   task automatic test_backpressure_reset();
      logic stable = 1'b1;
      out_ready = 1'b0;
      issue(4'd4, 32'h8000_00FF, 32'h0000_00F0);
      operation = 4'd0; a = 32'd7; b = 32'd9; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'h8000_000F ||
             {zero, negative, carry, overflow} !== 4'b0100) stable = 1'b0;
         step();
      end
      in_valid = 1'b0;
      total++;
      if (stable !== 1'b1) begin
         bad++;
         $display("FAIL hold: stable=%b result=%h required 1 8000000f", stable, result);
      end
      out_ready = 1'b1;
      step();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL release: v=%b rdy=%b required 0 1", out_valid, in_ready);
      end
      issue(4'd8, 32'd3, 32'd4);
      for (int i = 0; i < 9; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset: v=%b busy=%b result=%h rdy=%b required 0 0 0 1", out_valid, busy,
                  result, in_ready);
      end
      step();
      step();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_discard: v=%b busy=%b required 0 0", out_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_addsub();
      test_shift();
      test_mul();
      test_div();
      test_back_to_back();
      test_backpressure_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Registered result and flags, generic WIDTH, signed-overflow flag.
- Iterative unsigned multiply (low/high) and unsigned divide/remainder.
- Sits in the execute stage; the pipeline stalls on in_ready/out_valid while a multi-cycle op runs.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, >= 8).
- SHW, $clog2(WIDTH), shift-amount bits taken from b[SHW-1:0] (derived; do not override).

Ports:
- clk        input   1      system clock, all logic on rising edge
- rst        input   1      synchronous, active-high reset
- in_valid   input   1      operation request valid
- in_ready   output  1      block can accept a request this cycle
- operation  input   4      op code (encoding below)
- a          input   WIDTH  operand A
- b          input   WIDTH  operand B
- out_valid  output  1      result/flags valid
- out_ready  input   1      consumer accepts result
- result     output  WIDTH  registered result
- zero       output  1      result == 0
- negative   output  1      result[WIDTH-1]
- carry      output  1      unsigned carry/borrow (ADD/SUB only, else 0)
- overflow   output  1      signed overflow (ADD/SUB only, else 0)
- busy       output  1      iterative op in progress

Behaviour:
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA
  - 8 MUL (low WIDTH bits of a*b), 9 MULHU (high WIDTH bits, unsigned)
  - 10 DIVU, 11 REMU
  - 12-15: result 0, all flags computed from 0 (zero=1), single-cycle.
- Accept = in_valid && in_ready. Operands and op are captured on accept and are not sampled afterwards.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back single-cycle ops therefore sustain one per cycle when out_ready=1.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE/DONE + accept of op 0-7 or 12-15 -> DONE, result registered next edge (latency 1).
  - Accept of op 8/9 -> MUL; accept of op 10/11 -> DIV.
  - MUL/DIV run exactly WIDTH iterations, one bit per cycle (shift-add / restoring shift-subtract), then -> DONE. out_valid rises WIDTH+1 cycles after the accept edge.
  - DONE && out_ready && !accept -> IDLE.
  - DONE && !out_ready -> hold DONE.
- out_valid = (state==DONE). result and all flags stay stable while out_valid && !out_ready.
- busy = state in {MUL, DIV}. in_ready=0 while busy.
- carry:
  - ADD: carry-out of the WIDTH-bit sum.
  - SUB: 1 when a < b unsigned (borrow).
- overflow:
  - ADD: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from a.
- Shifts use b[SHW-1:0] only. SRA replicates a[WIDTH-1].
- Divide by zero keeps full WIDTH+1 latency:
  - DIVU -> all ones.
  - REMU -> a.
- Flags for ops 2-15: carry=0, overflow=0. zero and negative are always derived from result.
- Reset (any state, including mid-iteration): state=IDLE, out_valid=0, busy=0, result=0, zero=0, negative=0, carry=0, overflow=0. The in-flight op is discarded. in_ready=1 on the first cycle after rst deasserts.
- in_valid while !in_ready is ignored; no buffering. The requester holds the request.

Optional Feature:
- SEQ_ALU_DIV_EN.
  - Defined: DIV state and ops 10/11 implemented as above.
  - Undefined: no divider logic; ops 10/11 behave as single-cycle ops returning 0 (zero=1, carry=0, overflow=0), and DIV state is never entered.

Test Plan:
- Reset then ADD a=0xFFFFFFFF, b=1, out_ready=1 -> one cycle later out_valid=1, result=0, zero=1, carry=1, overflow=0; next cycle out_valid=0.
- ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, negative=1, overflow=1, carry=0. SUB a=3, b=5 -> result=0xFFFFFFFE, carry=1, overflow=0.
- SRA a=0x80000000, b=0x24 -> shift 4, result=0xF8000000. SLL a=1, b=31 -> 0x80000000.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> in_ready=0 and busy=1 for 32 cycles, out_valid at cycle 33, result=0xFFFFFFFE. MUL same operands -> 0x00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. With SEQ_ALU_DIV_EN undefined: DIVU 100/7 -> 0 after 1 cycle.
- Back-pressure/reset: hold out_ready=0 after an XOR -> result and flags stable for 5 cycles, in_ready=0. Then assert rst at MUL iteration 10 -> next cycle out_valid=0, busy=0, result=0, in_ready=1.
